// File: rtl/async_in_sync_filter.sv
// -----------------------------------------------------------------------------
// async_in_sync_filter
//
// Multi-channel synchroniser for independent single-bit signals entering the
// i_clk domain from a slower or fully asynchronous source. Each channel has an
// N-flop synchronisation chain, an optional glitch filter, a registered level
// output and single-cycle rise/fall pulses derived from that level.
//
// Channels are synchronised independently: this block must not be used for
// multi-bit buses, as there is no coherency between bits.
//
// Build option:
//   ASYNC_IN_SYNC_FILTER_EN  defined   -> per-channel glitch filter present; a new
//                                         level is accepted only after FILT_CYCLES
//                                         consecutive disagreeing samples.
//                            undefined -> no filter; the synchronised value is the
//                                         accepted level, FILT_CYCLES is ignored.
//
// Parameters:
//   CH           number of independent channels
//   SYNC_STAGES  synchroniser flops per channel (>= 2)
//   FILT_CYCLES  consecutive agreeing samples needed to accept a new level (>= 1)
//   RST_VAL      CH-bit reset value of the sync chain, accepted level and o_level
//
// Ports:
//   i_clk    in   1   destination clock
//   i_rst_n  in   1   asynchronous active-low reset
//   i_async  in   CH  asynchronous inputs, one per channel
//   o_level  out  CH  synchronised (filtered) level, registered
//   o_rise   out  CH  one-cycle pulse in the first cycle o_level[i] reads 1 after 0
//   o_fall   out  CH  one-cycle pulse in the first cycle o_level[i] reads 0 after 1
// -----------------------------------------------------------------------------
module async_in_sync_filter #(
  parameter int          CH          = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_CYCLES = 4,
  parameter logic [CH-1:0] RST_VAL   = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CH-1:0] i_async,
  output logic [CH-1:0] o_level,
  output logic [CH-1:0] o_rise,
  output logic [CH-1:0] o_fall
);

  // Parameter sanity: a single flop gives no metastability protection.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("async_in_sync_filter: SYNC_STAGES must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Synchronisation chain. Only stage 0 ever samples i_async; the remaining
  // stages give a metastable stage 0 time to resolve.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][CH-1:0] sync_d;
  logic [CH-1:0]                  sync_out;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Accepted level L (== o_level) and its next value.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] level_q;
  logic [CH-1:0] level_d;

`ifdef ASYNC_IN_SYNC_FILTER_EN
  if (FILT_CYCLES < 1) begin : g_bad_filt_cycles
    $error("async_in_sync_filter: FILT_CYCLES must be >= 1");
  end

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  // Per-channel run length of consecutive samples disagreeing with L.
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  // Any agreeing sample restarts the run, so a glitch shorter than
  // FILT_CYCLES cycles never reaches the accepted level. When the run
  // completes the new level is taken and the count restarts for the
  // opposite direction.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int unsigned c = 0; c < CH; c++) begin
      if (sync_out[c] == level_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_LAST) begin
        level_d[c] = sync_out[c];
        cnt_d[c]   = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Unfiltered: the synchroniser output is accepted directly.
  always_comb begin
    level_d = sync_out;
  end
`endif

  // ---------------------------------------------------------------------------
  // Level and edge pulses, all registered together so the pulse coincides with
  // the first cycle o_level shows the new value. Reset loads RST_VAL with no
  // pulse, so the reset value itself is never reported as an edge.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] rise_q;
  logic [CH-1:0] fall_q;
  logic [CH-1:0] rise_d;
  logic [CH-1:0] fall_d;

  always_comb begin
    rise_d = ~level_q &  level_d;
    fall_d =  level_q & ~level_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= RST_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: tb/tb_async_in_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_async_in_sync_filter
//
// Two instances share the stimulus:
//   A: SYNC_STAGES=2, FILT_CYCLES=4, RST_VAL=4'b0101
//   B: SYNC_STAGES=3, FILT_CYCLES=1, RST_VAL=4'b0000
// Inputs change on the falling edge, so every change is settled before the
// next rising edge. The reference model keeps the full history of sampled
// inputs since reset and decides each level from a window of that history:
// a channel flips when the FILT_CYCLES samples that have just come out of the
// synchroniser all disagree with the current level.
// -----------------------------------------------------------------------------
module tb_async_in_sync_filter;

  localparam int              CH = 4;
  localparam int              SA = 2;
  localparam int              FA = 4;
  localparam logic [CH-1:0]   RA = 4'b0101;
  localparam int              SB = 3;
  localparam int              FB = 1;
  localparam logic [CH-1:0]   RB = 4'b0000;
`ifdef ASYNC_IN_SYNC_FILTER_EN
  localparam int EFA = FA;
  localparam int EFB = FB;
`else
  localparam int EFA = 1;
  localparam int EFB = 1;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] din   = '0;
  logic [CH-1:0] a_lev, a_rise, a_fall;
  logic [CH-1:0] b_lev, b_rise, b_fall;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  async_in_sync_filter #(.CH(CH), .SYNC_STAGES(SA), .FILT_CYCLES(FA), .RST_VAL(RA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_async(din),
    .o_level(a_lev), .o_rise(a_rise), .o_fall(a_fall)
  );

  async_in_sync_filter #(.CH(CH), .SYNC_STAGES(SB), .FILT_CYCLES(FB), .RST_VAL(RB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_async(din),
    .o_level(b_lev), .o_rise(b_rise), .o_fall(b_fall)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [CH-1:0] samp [$];   // input sampled at each rising edge since reset
  logic [CH-1:0] ea_lev, ea_rise, ea_fall;
  logic [CH-1:0] eb_lev, eb_rise, eb_fall;

  // Level after the current edge. The value leaving the synchroniser at edge n
  // was sampled at edge n-s; before reset release the chain holds rv.
  function automatic logic [CH-1:0] next_level(logic [CH-1:0] cur, int s, int f,
                                               logic [CH-1:0] rv);
    logic [CH-1:0] nl;
    logic [CH-1:0] w;
    int n;
    n  = samp.size();
    nl = cur;
    for (int c = 0; c < CH; c++) begin
      bit flip;
      flip = 1'b1;
      for (int j = 0; j < f; j++) begin
        int idx;
        idx = n - s - j;
        w   = (idx < 0) ? rv : samp[idx];
        if (w[c] == cur[c]) flip = 1'b0;
      end
      if (flip) nl[c] = ~cur[c];
    end
    return nl;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp.delete();
      ea_lev  <= RA;
      ea_rise <= '0;
      ea_fall <= '0;
      eb_lev  <= RB;
      eb_rise <= '0;
      eb_fall <= '0;
    end else begin
      ea_lev  <= next_level(ea_lev, SA, EFA, RA);
      ea_rise <= ~ea_lev & next_level(ea_lev, SA, EFA, RA);
      ea_fall <= ea_lev & ~next_level(ea_lev, SA, EFA, RA);
      eb_lev  <= next_level(eb_lev, SB, EFB, RB);
      eb_rise <= ~eb_lev & next_level(eb_lev, SB, EFB, RB);
      eb_fall <= eb_lev & ~next_level(eb_lev, SB, EFB, RB);
      samp.push_back(din);
    end
  end

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    din   = RA;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_lev, a_rise, a_fall, b_lev, b_rise, b_fall} !== {RA, 4'h0, 4'h0, RB, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got a=%b/%b/%b b=%b/%b/%b required a=%b/0000/0000 b=%b/0000/0000",
               a_lev, a_rise, a_fall, b_lev, b_rise, b_fall, RA, RB);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if ({a_lev, a_rise, a_fall} !== {RA, 4'h0, 4'h0}) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got a=%b/%b/%b required %b/0000/0000",
                 i, a_lev, a_rise, a_fall, RA);
      end
      n_chk++;
      if ({b_lev, b_rise, b_fall} !== {eb_lev, eb_rise, eb_fall}) begin
        n_fail++;
        $display("FAIL reset_hold_b cyc %0d: got %b/%b/%b required %b/%b/%b",
                 i, b_lev, b_rise, b_fall, eb_lev, eb_rise, eb_fall);
      end
    end
  endtask

  // Channel 0 of A resets to 1: fall first, then rise, checking exact latency.
  task automatic test_edges();
    int seen;
    for (int ph = 0; ph < 2; ph++) begin
      din[0] = (ph == 1);
      seen = -1;
      for (int i = 1; i <= 14; i++) begin
        @(negedge clk);
        if (seen < 0 && ((ph == 1) ? a_rise[0] : a_fall[0])) seen = i;
        n_chk++;
        if ({a_lev, a_rise, a_fall, b_lev, b_rise, b_fall} !==
            {ea_lev, ea_rise, ea_fall, eb_lev, eb_rise, eb_fall}) begin
          n_fail++;
          $display("FAIL edges ph%0d cyc %0d: got a=%b/%b/%b b=%b/%b/%b required a=%b/%b/%b b=%b/%b/%b",
                   ph, i, a_lev, a_rise, a_fall, b_lev, b_rise, b_fall,
                   ea_lev, ea_rise, ea_fall, eb_lev, eb_rise, eb_fall);
        end
        if (i == SA + EFA + 1) begin
          n_chk++;
          if ({a_rise[0], a_fall[0], a_lev[0]} !== {1'b0, 1'b0, ph[0]}) begin
            n_fail++;
            $display("FAIL edge_pulse_width ph%0d: got rise=%b fall=%b lev=%b required 0 0 %0d",
                     ph, a_rise[0], a_fall[0], a_lev[0], ph);
          end
        end
      end
      n_chk++;
      if (seen != SA + EFA) begin
        n_fail++;
        $display("FAIL edge_latency ph%0d: got %0d required %0d", ph, seen, SA + EFA);
      end
    end
  endtask

  // Channel 1 of A: 3-cycle glitch, then a 4-cycle pulse.
  task automatic test_filter();
    int rises;
    int seen;
    din   = 4'b0100;
    repeat (12) @(negedge clk);
    rises = 0;
    for (int i = 0; i < 16; i++) begin
      din[1] = (i < 3);
      @(negedge clk);
      rises += a_rise[1];
      n_chk++;
      if ({a_lev, a_rise, a_fall} !== {ea_lev, ea_rise, ea_fall}) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got %b/%b/%b required %b/%b/%b",
                 i, a_lev, a_rise, a_fall, ea_lev, ea_rise, ea_fall);
      end
    end
    n_chk++;
    if (rises != ((EFA > 3) ? 0 : 1)) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d required %0d", rises, (EFA > 3) ? 0 : 1);
    end
    seen = -1;
    for (int i = 1; i <= 16; i++) begin
      din[1] = (i <= 4);
      @(negedge clk);
      if (seen < 0 && a_rise[1]) seen = i;
    end
    n_chk++;
    if (seen != SA + EFA) begin
      n_fail++;
      $display("FAIL filter_4cyc_latency: got %0d required %0d", seen, SA + EFA);
    end
  endtask

  // Channel 2: high 3, low 1, high 4 then held high.
  task automatic test_glitch_restart();
    int rises;
    int first;
    din = 4'b0000;
    repeat (14) @(negedge clk);
    rises = 0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      din[2] = (i != 3);
      @(negedge clk);
      if (a_rise[2]) begin
        rises++;
        if (first < 0) first = i + 1;
      end
      n_chk++;
      if ({a_lev, a_rise, a_fall} !== {ea_lev, ea_rise, ea_fall}) begin
        n_fail++;
        $display("FAIL restart cyc %0d: got %b/%b/%b required %b/%b/%b",
                 i, a_lev, a_rise, a_fall, ea_lev, ea_rise, ea_fall);
      end
    end
    n_chk++;
    if (rises != ((EFA > 3) ? 1 : 2)) begin
      n_fail++;
      $display("FAIL restart_pulses: got %0d required %0d", rises, (EFA > 3) ? 1 : 2);
    end
    // Filtered: counted from the change at i=4; unfiltered: from i=0.
    n_chk++;
    if (first != ((EFA > 3) ? 4 + SA + EFA : SA + EFA)) begin
      n_fail++;
      $display("FAIL restart_first_rise: got %0d required %0d",
               first, (EFA > 3) ? 4 + SA + EFA : SA + EFA);
    end
  endtask

  // Instance B: all channels 0 -> 1 on one edge.
  task automatic test_all_channels();
    din = 4'b0000;
    repeat (12) @(negedge clk);
    din = 4'b1111;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (b_rise !== ((i == SB + EFB) ? 4'b1111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL all_ch_rise cyc %0d: got %b required %b",
                 i, b_rise, (i == SB + EFB) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  // Reset while A channel 1 is part-way through its filter count.
  task automatic test_reset_mid();
    int rises;
    int seen;
    din = RA;
    repeat (12) @(negedge clk);
    din[1] = 1'b1;
    repeat (SA + 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_lev, a_rise, a_fall, b_lev, b_rise, b_fall} !== {RA, 4'h0, 4'h0, RB, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_state: got a=%b/%b/%b b=%b/%b/%b required a=%b/0000/0000 b=%b/0000/0000",
               a_lev, a_rise, a_fall, b_lev, b_rise, b_fall, RA, RB);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({a_rise, a_fall, b_rise, b_fall} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_mid_pulses cyc %0d: got %b%b%b%b required 0",
                 i, a_rise, a_fall, b_rise, b_fall);
      end
    end
    rst_n = 1'b1;
    rises = 0;
    seen  = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (a_rise[1]) begin
        rises++;
        if (seen < 0) seen = i;
      end
      n_chk++;
      if ({a_lev, a_rise, a_fall, b_lev, b_rise, b_fall} !==
          {ea_lev, ea_rise, ea_fall, eb_lev, eb_rise, eb_fall}) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc %0d: got a=%b/%b/%b b=%b/%b/%b required a=%b/%b/%b b=%b/%b/%b",
                 i, a_lev, a_rise, a_fall, b_lev, b_rise, b_fall,
                 ea_lev, ea_rise, ea_fall, eb_lev, eb_rise, eb_fall);
      end
    end
    n_chk++;
    if (rises != 1 || seen != SA + EFA) begin
      n_fail++;
      $display("FAIL reset_mid_edge: got %0d pulses first at %0d required 1 at %0d",
               rises, seen, SA + EFA);
    end
  endtask

  // Random runs of random lengths, including sub-filter glitches.
  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        din  = 4'($urandom);
        hold = $urandom_range(1, 6);
      end
      hold--;
      @(negedge clk);
      n_chk++;
      if ({a_lev, a_rise, a_fall, b_lev, b_rise, b_fall} !==
          {ea_lev, ea_rise, ea_fall, eb_lev, eb_rise, eb_fall}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got a=%b/%b/%b b=%b/%b/%b required a=%b/%b/%b b=%b/%b/%b",
                 i, a_lev, a_rise, a_fall, b_lev, b_rise, b_fall,
                 ea_lev, ea_rise, ea_fall, eb_lev, eb_rise, eb_fall);
      end
      n_chk++;
      if (((a_rise & a_fall) | (b_rise & b_fall)) !== 4'h0) begin
        n_fail++;
        $display("FAIL random_both_pulses cyc %0d: got a=%b/%b b=%b/%b required disjoint",
                 i, a_rise, a_fall, b_rise, b_fall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edges();
    test_filter();
    test_glitch_restart();
    test_all_channels();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
